// File: rtl/el2_ifu_ic_arb.sv
// Arbiter/sequencer sharing the I-cache array port between fetch reads,
// miss-fill beat writes and debug array accesses.
module el2_ifu_ic_arb #(
    parameter int FILL_BEATS = 8,
    parameter int ADDR_W     = 31
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    input  logic              fill_valid_i,
    input  logic [ADDR_W-1:0] fill_addr_i,
    input  logic [1:0]        fill_way_i,
    output logic              fill_ready_o,
    output logic              fill_done_o,
    input  logic              dbg_req_i,
    input  logic              dbg_wr_i,
    input  logic [8:0]        dbg_addr_i,
    input  logic              dbg_tag_i,
    input  logic [1:0]        dbg_way_i,
    output logic              dbg_done_o,
    output logic [70:0]       dbg_rd_data_o,
    output logic [ADDR_W-1:0] ic_rw_addr_o,
    output logic              ic_rd_en_o,
    output logic [1:0]        ic_wr_en_o,
    output logic              ic_debug_rd_en_o,
    output logic              ic_debug_wr_en_o,
    output logic              ic_debug_tag_array_o,
    output logic [8:0]        ic_debug_addr_o,
    output logic [1:0]        ic_debug_way_o,
    input  logic [70:0]       ic_debug_rd_data_in_i,
    input  logic [1:0]        ic_eccerr_in_i,
    input  logic [1:0]        ic_parerr_in_i,
    input  logic              ic_tag_perr_in_i,
    input  logic              ecc_disable_i,
    output logic              rd_valid_o,
    output logic              rd_err_o
);

    localparam int CNT_W = $clog2(FILL_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FILL_BEATS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DBG_RD, DBG_WAIT} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              rd_valid_q;
    logic [70:0]       dbg_rd_data_q;

    logic fetch_go, fill_wr, fill_last, dbg_rd_go, dbg_wr_go, dbg_done;

    // Grants are gated by reset so every output is quiet while rst_ni is low.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        fetch_go  = 1'b0;
        fill_wr   = 1'b0;
        fill_last = 1'b0;
        dbg_rd_go = 1'b0;
        dbg_wr_go = 1'b0;
        dbg_done  = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    if (fill_valid_i) begin
                        fill_wr = 1'b1;
                        beat_d  = CNT_W'(1);
                        state_d = FILL;
                    end else if (dbg_req_i) begin
                        if (dbg_wr_i) begin
                            dbg_wr_go = 1'b1;
                            dbg_done  = 1'b1;
                        end else begin
                            dbg_rd_go = 1'b1;
                            state_d   = DBG_RD;
                        end
                    end else if (fetch_req_i) begin
                        fetch_go = 1'b1;
                    end
                end
                FILL: begin
                    if (fill_valid_i) begin
                        fill_wr = 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            fill_last = 1'b1;
                            beat_d    = '0;
                            state_d   = IDLE;
                        end else begin
                            beat_d = beat_q + CNT_W'(1);
                        end
                    end
                end
                DBG_RD:   state_d = DBG_WAIT;
                DBG_WAIT: begin
                    dbg_done = 1'b1;
                    state_d  = IDLE;
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            rd_valid_q    <= 1'b0;
            dbg_rd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            rd_valid_q <= fetch_go;
            // Array read latency is one cycle: data is valid while in DBG_RD.
            if (state_q == DBG_RD) begin
                dbg_rd_data_q <= ic_debug_rd_data_in_i;
            end
        end
    end

    assign fetch_gnt_o  = fetch_go;
    assign fill_ready_o = fill_wr;
    assign fill_done_o  = fill_last;
    assign dbg_done_o   = dbg_done;
    assign dbg_rd_data_o = dbg_rd_data_q;

    assign ic_rd_en_o   = fetch_go;
    assign ic_wr_en_o   = fill_wr ? fill_way_i : 2'b00;
    assign ic_rw_addr_o = fetch_go ? fetch_addr_i :
                          fill_wr  ? fill_addr_i  : '0;

    assign ic_debug_rd_en_o     = dbg_rd_go;
    assign ic_debug_wr_en_o     = dbg_wr_go;
    assign ic_debug_tag_array_o = (dbg_rd_go | dbg_wr_go) & dbg_tag_i;
    assign ic_debug_addr_o      = (dbg_rd_go | dbg_wr_go) ? dbg_addr_i : 9'd0;
    assign ic_debug_way_o       = (dbg_rd_go | dbg_wr_go) ? dbg_way_i : 2'b00;

    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_valid_q & ((|(ic_eccerr_in_i & ~{2{ecc_disable_i}}))
                                      | (|ic_parerr_in_i) | ic_tag_perr_in_i);

endmodule

// File: tb/tb_el2_ifu_ic_arb.sv
// Directed self-checking bench for el2_ifu_ic_arb (FILL_BEATS=8, ADDR_W=31).
module tb_el2_ifu_ic_arb;

    localparam int ADDR_W = 31;
    localparam logic [70:0] DBG_DATA = 71'h5A_A5A5_1234_5678_9ABC;

    logic              clk, rst_n;
    logic              fetch_req, fetch_gnt;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fill_valid, fill_ready, fill_done;
    logic [ADDR_W-1:0] fill_addr;
    logic [1:0]        fill_way;
    logic              dbg_req, dbg_wr, dbg_tag, dbg_done;
    logic [8:0]        dbg_addr;
    logic [1:0]        dbg_way;
    logic [70:0]       dbg_rd_data;
    logic [ADDR_W-1:0] ic_rw_addr;
    logic              ic_rd_en;
    logic [1:0]        ic_wr_en;
    logic              ic_debug_rd_en, ic_debug_wr_en, ic_debug_tag_array;
    logic [8:0]        ic_debug_addr;
    logic [1:0]        ic_debug_way;
    logic [70:0]       ic_debug_rd_data_in;
    logic [1:0]        ic_eccerr_in, ic_parerr_in;
    logic              ic_tag_perr_in, ecc_disable;
    logic              rd_valid, rd_err;

    int checks   = 0;
    int failures = 0;

    el2_ifu_ic_arb #(.FILL_BEATS(8), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
        .fill_valid_i(fill_valid), .fill_addr_i(fill_addr), .fill_way_i(fill_way),
        .fill_ready_o(fill_ready), .fill_done_o(fill_done),
        .dbg_req_i(dbg_req), .dbg_wr_i(dbg_wr), .dbg_addr_i(dbg_addr),
        .dbg_tag_i(dbg_tag), .dbg_way_i(dbg_way), .dbg_done_o(dbg_done),
        .dbg_rd_data_o(dbg_rd_data),
        .ic_rw_addr_o(ic_rw_addr), .ic_rd_en_o(ic_rd_en), .ic_wr_en_o(ic_wr_en),
        .ic_debug_rd_en_o(ic_debug_rd_en), .ic_debug_wr_en_o(ic_debug_wr_en),
        .ic_debug_tag_array_o(ic_debug_tag_array), .ic_debug_addr_o(ic_debug_addr),
        .ic_debug_way_o(ic_debug_way), .ic_debug_rd_data_in_i(ic_debug_rd_data_in),
        .ic_eccerr_in_i(ic_eccerr_in), .ic_parerr_in_i(ic_parerr_in),
        .ic_tag_perr_in_i(ic_tag_perr_in), .ecc_disable_i(ecc_disable),
        .rd_valid_o(rd_valid), .rd_err_o(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One fill beat cycle: drive, sample at negedge, advance.
    task automatic fill_cycle(input string tag, input logic valid, input int beat,
                              input logic exp_done);
        fill_valid = valid;
        fill_addr  = ADDR_W'(32'h200 + beat);
        @(negedge clk);
        check({tag, "_ready"}, fill_ready, valid);
        check({tag, "_wr_en"}, ic_wr_en, valid ? fill_way : 2'b00);
        check({tag, "_done"}, fill_done, exp_done);
        check({tag, "_fetch_gnt"}, fetch_gnt, 1'b0);
        check({tag, "_rd_en"}, ic_rd_en, 1'b0);
        if (valid) check({tag, "_addr"}, ic_rw_addr, fill_addr);
        $display("fill %s beat=%0d valid=%0b wr_en=%b done=%0b", tag, beat, valid, ic_wr_en, fill_done);
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_req = 1'b1; fetch_addr = '0;
        fill_valid = 1'b0; fill_addr = '0; fill_way = 2'b10;
        dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_tag = 1'b0; dbg_way = 2'b00;
        ic_debug_rd_data_in = '0; ic_eccerr_in = '0; ic_parerr_in = '0;
        ic_tag_perr_in = 1'b0; ecc_disable = 1'b0;

        // Reset state, with a fetch request pending that must not be granted.
        repeat (2) @(negedge clk);
        check("rst_fetch_gnt", fetch_gnt, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_dbg_data", dbg_rd_data, 71'd0);
        check("rst_rd_en", ic_rd_en, 1'b0);
        $display("reset gnt=%0b rd_valid=%0b", fetch_gnt, rd_valid);
        fetch_req = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        // Fetch stream 0x100..0x103.
        for (int i = 0; i < 4; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = ADDR_W'(32'h100 + i);
            @(negedge clk);
            check("fetch_gnt", fetch_gnt, 1'b1);
            check("fetch_rd_en", ic_rd_en, 1'b1);
            check("fetch_addr", ic_rw_addr, fetch_addr);
            check("fetch_rd_valid", rd_valid, i > 0);
            check("fetch_rd_err", rd_err, 1'b0);
            $display("fetch addr=%0h gnt=%0b rd_valid=%0b", ic_rw_addr, fetch_gnt, rd_valid);
            next_cycle();
        end
        fetch_req = 1'b0;
        @(negedge clk);
        check("fetch_last_valid", rd_valid, 1'b1);
        next_cycle();
        @(negedge clk);
        check("fetch_idle_valid", rd_valid, 1'b0);
        ic_eccerr_in = 2'b01;
        #1 check("err_no_valid", rd_err, 1'b0);
        ic_eccerr_in = 2'b00;
        next_cycle();

        // Error qualification on a response cycle.
        fetch_req = 1'b1; fetch_addr = ADDR_W'(32'h180);
        next_cycle();
        fetch_req = 1'b0;
        ic_eccerr_in = 2'b01; ecc_disable = 1'b1;
        #1 check("err_ecc_disabled", rd_err, 1'b0);
        ecc_disable = 1'b0;
        #1 check("err_ecc_enabled", rd_err, 1'b1);
        ic_eccerr_in = 2'b00; ic_tag_perr_in = 1'b1;
        #1 check("err_tag_perr", rd_err, 1'b1);
        ic_tag_perr_in = 1'b0; ic_parerr_in = 2'b10;
        #1 check("err_parerr", rd_err, 1'b1);
        ic_parerr_in = 2'b00;
        $display("errors checked rd_valid=%0b", rd_valid);
        next_cycle();

        // Fill with a gap after beat 3; fetch held high throughout.
        fetch_req = 1'b1; fetch_addr = ADDR_W'(32'h300); fill_way = 2'b10;
        for (int b = 0; b < 4; b++) fill_cycle("fillA", 1'b1, b, 1'b0);
        fill_cycle("fillA_gap", 1'b0, 4, 1'b0);
        for (int b = 4; b < 8; b++) fill_cycle("fillA", 1'b1, b, b == 7);
        fill_valid = 1'b0;
        @(negedge clk);
        check("post_fill_fetch", fetch_gnt, 1'b1);
        check("post_fill_rd_valid", rd_valid, 1'b0);
        next_cycle();

        // Simultaneous fill, debug read, fetch: fill, then debug, then fetch.
        fill_way = 2'b01;
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 9'h1A5; dbg_tag = 1'b1; dbg_way = 2'b01;
        for (int b = 0; b < 8; b++) begin
            fill_cycle("fillB", 1'b1, b, b == 7);
        end
        fill_valid = 1'b0;
        @(negedge clk);
        check("dbg_rd_en", ic_debug_rd_en, 1'b1);
        check("dbg_issue_fetch", fetch_gnt, 1'b0);
        check("dbg_addr", ic_debug_addr, 9'h1A5);
        check("dbg_tag", ic_debug_tag_array, 1'b1);
        check("dbg_way", ic_debug_way, 2'b01);
        check("dbg_issue_done", dbg_done, 1'b0);
        $display("dbg read issued addr=%0h", ic_debug_addr);
        next_cycle();
        dbg_req = 1'b0;
        ic_debug_rd_data_in = DBG_DATA;
        @(negedge clk);
        check("dbg_rd_phase_en", ic_debug_rd_en, 1'b0);
        check("dbg_rd_phase_fetch", fetch_gnt, 1'b0);
        check("dbg_rd_phase_done", dbg_done, 1'b0);
        next_cycle();
        ic_debug_rd_data_in = '0;
        @(negedge clk);
        check("dbg_wait_done", dbg_done, 1'b1);
        check("dbg_wait_data", dbg_rd_data, DBG_DATA);
        check("dbg_wait_fetch", fetch_gnt, 1'b0);
        check("dbg_wait_rd_valid", rd_valid, 1'b0);
        $display("dbg read done data=%0h", dbg_rd_data);
        next_cycle();
        @(negedge clk);
        check("after_dbg_fetch", fetch_gnt, 1'b1);
        check("after_dbg_done", dbg_done, 1'b0);
        check("dbg_data_hold", dbg_rd_data, DBG_DATA);
        next_cycle();

        // Debug write beats a pending fetch and completes in one cycle.
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 9'h033; dbg_tag = 1'b0; dbg_way = 2'b10;
        @(negedge clk);
        check("dbgw_wr_en", ic_debug_wr_en, 1'b1);
        check("dbgw_done", dbg_done, 1'b1);
        check("dbgw_fetch", fetch_gnt, 1'b0);
        check("dbgw_ic_wr_en", ic_wr_en, 2'b00);
        check("dbgw_addr", ic_debug_addr, 9'h033);
        $display("dbg write addr=%0h done=%0b", ic_debug_addr, dbg_done);
        next_cycle();
        dbg_req = 1'b0; dbg_wr = 1'b0;
        @(negedge clk);
        check("after_dbgw_fetch", fetch_gnt, 1'b1);
        next_cycle();
        fetch_req = 1'b0;

        // Reset at fill beat 5, then a fresh fill needs 8 beats.
        fill_way = 2'b10;
        for (int b = 0; b < 5; b++) fill_cycle("fillC", 1'b1, b, 1'b0);
        fill_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_fill_ready", fill_ready, 1'b0);
        check("rst_fill_done", fill_done, 1'b0);
        check("rst_wr_en", ic_wr_en, 2'b00);
        $display("reset mid-fill ready=%0b done=%0b", fill_ready, fill_done);
        next_cycle();
        fill_valid = 1'b0;
        rst_n = 1'b1;
        next_cycle();
        for (int b = 0; b < 8; b++) fill_cycle("fillD", 1'b1, b, b == 7);
        fill_valid = 1'b0;
        @(negedge clk);
        check("fillD_idle_ready", fill_ready, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
